// File: rtl/pcileech_cfgspace_host_arbiter.sv
// pcileech_cfgspace_host_arbiter
// Owns the host port (Port B) of the 4 KB config-space shadow BRAM.
// After reset a loader streams the donor config image into the shadow as
// sequential dword writes. The design then moves to RUN and shares the port
// between a management requester (REQ0, read/write) and a monitor requester
// (REQ1, read-only) using round-robin arbitration. Read data returns on one
// tagged response channel.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   init_valid/data/ready       donor image dword stream
//   init_done                   loader finished, arbiter in RUN
//   req0_*                      management request channel (read/write)
//   req1_*                      monitor request channel (read only)
//   req1_wr_err                 pulse when a dropped REQ1 write is accepted
//   rsp_valid/id/rdata          read response channel, no backpressure
//   host_*                      shadow BRAM Port B (1-cycle read latency)
module pcileech_cfgspace_host_arbiter #(
    parameter int unsigned INIT_DWORDS = 1024,
    parameter bit          INIT_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_valid,
    input  logic [31:0] init_data,
    output logic        init_ready,
    output logic        init_done,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [11:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [11:0] req1_addr,
    output logic        req1_ready,
    output logic        req1_wr_err,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        host_access_en,
    output logic        host_write_en,
    output logic [11:0] host_addr,
    output logic [31:0] host_write_data,
    input  logic [31:0] host_read_data
);

    localparam int unsigned IDX_W  = 10;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               last_grant;
    logic               rd_pend;
    logic               rd_id;

    logic               in_init;
    logic               in_run;
    logic               init_acc;
    logic               last_init;
    logic               grant0;
    logic               grant1;
    logic               rd_acc;
    logic               unused_addr_lsbs;

    // Dword alignment discards the byte-lane bits of both request addresses.
    assign unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

    // Handshakes and round-robin grant; rst forces every output low.
    always_comb begin
        in_init   = (state == ST_INIT) && !rst;
        in_run    = (state == ST_RUN) && !rst;
        init_acc  = in_init && init_valid;
        last_init = init_acc && (idx == IDX_W'(INIT_DWORDS - 1));
        // On contention the requester that did not win last time goes next.
        grant0    = in_run && req0_valid && (!req1_valid || last_grant);
        grant1    = in_run && req1_valid && (!req0_valid || !last_grant);
        rd_acc    = (grant0 && !req0_write) || (grant1 && !req1_write);
    end

    // Port B drive: loader writes, REQ0 accesses, REQ1 reads (REQ1 writes dropped).
    always_comb begin
        init_ready      = in_init;
        req0_ready      = grant0;
        req1_ready      = grant1;
        host_access_en  = 1'b0;
        host_write_en   = 1'b0;
        host_addr       = '0;
        host_write_data = '0;
        if (init_acc) begin
            host_access_en  = 1'b1;
            host_write_en   = 1'b1;
            host_addr       = {idx, 2'b00};
            host_write_data = init_data;
        end else if (grant0) begin
            host_access_en  = 1'b1;
            host_write_en   = req0_write;
            host_addr       = {req0_addr[ADDR_W-1:2], 2'b00};
            host_write_data = req0_write ? req0_wdata : DATA_W'(0);
        end else if (grant1 && !req1_write) begin
            host_access_en  = 1'b1;
            host_addr       = {req1_addr[ADDR_W-1:2], 2'b00};
        end
    end

    // State, loader index, arbitration history and the 2-stage read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_ENABLE ? ST_INIT : ST_RUN;
            idx         <= '0;
            last_grant  <= 1'b1;
            rd_pend     <= 1'b0;
            rd_id       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_rdata   <= '0;
            req1_wr_err <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            if (last_init) begin
                state <= ST_RUN;
            end
            if (init_acc) begin
                idx <= idx + IDX_W'(1);
            end
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
            // Stage 1: BRAM sees the address; stage 2: capture its read data.
            rd_pend   <= rd_acc;
            rd_id     <= grant1;
            rsp_valid <= rd_pend;
            rsp_id    <= rd_id;
            if (rd_pend) begin
                rsp_rdata <= host_read_data;
            end
            req1_wr_err <= grant1 && req1_write;
            init_done   <= (state == ST_RUN) || last_init;
        end
    end

endmodule

// File: tb/tb_pcileech_cfgspace_host_arbiter.sv
// Directed bench for pcileech_cfgspace_host_arbiter with a small BRAM model
// on the host port (1-cycle registered read, prior contents for unwritten dwords).
module tb_pcileech_cfgspace_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_valid;
    logic [31:0] init_data;
    logic        init_ready;
    logic        init_done;
    logic        req0_valid;
    logic        req0_write;
    logic [11:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        req1_valid;
    logic        req1_write;
    logic [11:0] req1_addr;
    logic        req1_ready;
    logic        req1_wr_err;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        host_access_en;
    logic        host_write_en;
    logic [11:0] host_addr;
    logic [31:0] host_write_data;
    logic [31:0] host_read_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcileech_cfgspace_host_arbiter #(
        .INIT_DWORDS (4),
        .INIT_ENABLE (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .init_valid      (init_valid),
        .init_data       (init_data),
        .init_ready      (init_ready),
        .init_done       (init_done),
        .req0_valid      (req0_valid),
        .req0_write      (req0_write),
        .req0_addr       (req0_addr),
        .req0_wdata      (req0_wdata),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_write      (req1_write),
        .req1_addr       (req1_addr),
        .req1_ready      (req1_ready),
        .req1_wr_err     (req1_wr_err),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_rdata       (rsp_rdata),
        .host_access_en  (host_access_en),
        .host_write_en   (host_write_en),
        .host_addr       (host_addr),
        .host_write_data (host_write_data),
        .host_read_data  (host_read_data)
    );

    // Shadow BRAM model: unwritten dwords return their prior contents.
    logic [31:0] mem [1024];
    bit   [1023:0] written;
    logic [31:0] rd_q;

    function automatic logic [31:0] prior(input logic [9:0] a);
        if (a == 10'h1FF) return 32'hDEADBEEF;
        if (a == 10'h004) return 32'h11112222;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (host_access_en && host_write_en) begin
            mem[host_addr[11:2]]     <= host_write_data;
            written[host_addr[11:2]] <= 1'b1;
        end
        if (host_access_en && !host_write_en) begin
            rd_q <= written[host_addr[11:2]] ? mem[host_addr[11:2]] : prior(host_addr[11:2]);
        end
    end
    assign host_read_data = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        init_valid = 1'b0; init_data = '0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0;

        // Reset state: all outputs low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_ready", init_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_access", host_access_en, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_err", req1_wr_err, 0);
        rst = 1'b0;
        #1;
        chk("init_ready_after_rst", init_ready, 1);

        // Loader: A0, A1, gap of two cycles, A2, A3; requests held off in INIT.
        step(); init_valid = 1'b1; init_data = 32'hA0; req0_valid = 1'b1; #1;
        chk("ld0_access", host_access_en, 1);
        chk("ld0_write", host_write_en, 1);
        chk("ld0_addr", host_addr, 12'h000);
        chk("ld0_data", host_write_data, 32'hA0);
        chk("ld0_req0_ready", req0_ready, 0);
        step(); init_data = 32'hA1; req0_valid = 1'b0; #1;
        chk("ld1_addr", host_addr, 12'h004);
        chk("ld1_data", host_write_data, 32'hA1);
        step(); init_valid = 1'b0; #1;
        chk("gap0_access", host_access_en, 0);
        step(); #1;
        chk("gap1_access", host_access_en, 0);
        step(); init_valid = 1'b1; init_data = 32'hA2; #1;
        chk("ld2_addr", host_addr, 12'h008);
        step(); init_data = 32'hA3; #1;
        chk("ld3_addr", host_addr, 12'h00C);
        chk("ld3_data", host_write_data, 32'hA3);
        chk("ld3_done_low", init_done, 0);
        step(); init_valid = 1'b1; init_data = 32'hEE; #1;
        chk("init_done", init_done, 1);
        chk("run_init_ready", init_ready, 0);
        chk("run_ignores_init", host_access_en, 0);

        // REQ0 write 0x004 = 0x406, then read it back.
        step(); init_valid = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 12'h004; req0_wdata = 32'h406; #1;
        chk("w_req0_ready", req0_ready, 1);
        chk("w_access", host_access_en, 1);
        chk("w_we", host_write_en, 1);
        chk("w_addr", host_addr, 12'h004);
        chk("w_data", host_write_data, 32'h406);
        step(); req0_write = 1'b0; #1;
        chk("r_req0_ready", req0_ready, 1);
        chk("r_we", host_write_en, 0);
        chk("r_addr", host_addr, 12'h004);
        step(); req0_valid = 1'b0; #1;
        chk("r_rsp_t1", rsp_valid, 0);
        step(); #1;
        chk("r_rsp_t2", rsp_valid, 1);
        chk("r_rsp_id", rsp_id, 0);
        chk("r_rsp_data", rsp_rdata, 32'h406);
        step(); #1;
        chk("r_rsp_t3", rsp_valid, 0);

        // REQ1 write to 0x010 is accepted and dropped.
        step(); req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 12'h010; #1;
        chk("w1_ready", req1_ready, 1);
        chk("w1_access", host_access_en, 0);
        chk("w1_err_t0", req1_wr_err, 0);
        step(); req1_valid = 1'b0; req1_write = 1'b0; #1;
        chk("w1_err_t1", req1_wr_err, 1);
        chk("w1_no_rsp", rsp_valid, 0);
        step(); #1;
        chk("w1_err_t2", req1_wr_err, 0);

        // Contention for 6 cycles: REQ1 won last, so REQ0 goes first.
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 6) begin
                req0_valid = 1'b1; req0_addr = 12'h000;
                req1_valid = 1'b1; req1_addr = 12'h008;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (i < 6) begin
                chk($sformatf("rr%0d_req0_ready", i), req0_ready, (i % 2 == 0));
                chk($sformatf("rr%0d_req1_ready", i), req1_ready, (i % 2 == 1));
                chk($sformatf("rr%0d_addr", i), host_addr, (i % 2 == 1) ? 12'h008 : 12'h000);
            end
            if (i >= 2) begin
                chk($sformatf("rr%0d_rsp_valid", i), rsp_valid, 1);
                chk($sformatf("rr%0d_rsp_id", i), rsp_id, ((i - 2) % 2 == 1));
                chk($sformatf("rr%0d_rsp_data", i), rsp_rdata,
                    ((i - 2) % 2 == 1) ? 32'hA2 : 32'hA0);
            end else begin
                chk($sformatf("rr%0d_rsp_idle", i), rsp_valid, 0);
            end
        end

        // Unaligned 0x7FF, then 0x010 (beyond loaded range, REQ1 write dropped).
        step(); req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 12'h7FF; #1;
        chk("a_addr", host_addr, 12'h7FC);
        chk("a_access", host_access_en, 1);
        step(); req0_addr = 12'h010; #1;
        chk("b_addr", host_addr, 12'h010);
        step(); req0_valid = 1'b0; #1;
        chk("a_rsp_valid", rsp_valid, 1);
        chk("a_rsp_data", rsp_rdata, 32'hDEADBEEF);
        step(); #1;
        chk("b_rsp_valid", rsp_valid, 1);
        chk("b_rsp_data", rsp_rdata, 32'h11112222);
        step(); #1;
        chk("b_rsp_end", rsp_valid, 0);

        // Reset one cycle after a read accept discards the read and restarts the loader.
        step(); req0_valid = 1'b1; req0_addr = 12'h000; #1;
        chk("x_req0_ready", req0_ready, 1);
        step(); req0_valid = 1'b0; rst = 1'b1; #1;
        chk("x_rst_access", host_access_en, 0);
        step(); rst = 1'b0; init_valid = 1'b1; init_data = 32'hB0; #1;
        chk("x_no_rsp", rsp_valid, 0);
        chk("x_init_done", init_done, 0);
        chk("x_ld_addr0", host_addr, 12'h000);
        chk("x_ld_access", host_access_en, 1);
        step(); init_data = 32'hB1; #1;
        chk("x_no_rsp2", rsp_valid, 0);
        chk("x_ld_addr1", host_addr, 12'h004);
        step(); init_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
